i2c_event_scheduler: RTL and testbench

- Sits between the game logic outputs and the I2C LCD transmitter, which is a single shared resource.
- Captures asynchronous game events (ladder up/down per player, round win, final result, restart) as pending requests.
- Arbitrates them by fixed priority and issues one message at a time over a req/ack/done handshake.
- Enforces a minimum on-screen hold time between messages so no event is lost or overwritten mid-display.

---
 rtl/i2c_event_scheduler.sv | 179 +++++++++++++++++
 tb/tb_i2c_event_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_event_scheduler.sv
// Event scheduler in front of the shared I2C LCD transmitter. It captures game events as pending
// requests, issues them one at a time in fixed priority order, and keeps each message on screen for a minimum hold time.
module i2c_event_scheduler #(
  parameter int HOLD_CYCLES    = 100_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic       game_final,
  input  logic [1:0] game_result,
  input  logic       i2c_show_signal,
  input  logic [1:0] game_win,
  input  logic       up_signal_p1,
  input  logic       down_signal_p1,
  input  logic       up_signal_p2,
  input  logic       down_signal_p2,
  output logic       tx_req,
  output logic [2:0] msg_code,
  output logic [1:0] msg_arg,
  input  logic       tx_ack,
  input  logic       tx_done,
  output logic [6:0] pending,
  output logic       busy,
  output logic [7:0] coalesce_cnt,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    HOLD      = 2'd3
  } state_t;

  localparam logic [31:0] HOLD_LAST    = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic        HOLD_EN      = (HOLD_CYCLES != 0) ? 1'b1 : 1'b0;

  state_t      state_r;
  logic [6:0]  ev_in_s, ev_d_r, edge_s;
  logic [6:0]  pending_r, pend_nxt_s, clr_mask_s, merge_s;
  logic [1:0]  final_arg_r, win_arg_r, arg_sel_s;
  logic [2:0]  sel_s;
  logic        pick_s;
  logic [8:0]  coal_sum_s;
  logic [7:0]  coal_r, coal_nxt_s;
  logic        tx_req_r, busy_r, tout_r;
  logic [2:0]  code_r;
  logic [1:0]  arg_r;
  logic [31:0] timer_r, hold_cnt_r;

  function automatic logic [2:0] top_index(input logic [6:0] p);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (p[i]) idx = 3'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  function automatic logic [2:0] count_ones(input logic [6:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 7; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  assign ev_in_s = {down_signal_p2, up_signal_p2, down_signal_p1, up_signal_p1,
                    i2c_show_signal, game_final, restart};
  assign edge_s  = ev_in_s & ~ev_d_r;

  // Next pending bitmap, priority pick and coalesce accounting
  always_comb begin
    pick_s     = (state_r == IDLE) && (pending_r != 7'd0);
    sel_s      = top_index(pending_r);
    clr_mask_s = pick_s ? (7'd1 << sel_s) : 7'd0;
    merge_s    = edge_s & pending_r & ~clr_mask_s;
    // A fresh edge on the bit being handed out re-arms it
    pend_nxt_s = (pending_r & ~clr_mask_s) | edge_s;
    if (edge_s[0]) pend_nxt_s = 7'b0000001;
    else           pend_nxt_s = pend_nxt_s;
    coal_sum_s = {1'b0, coal_r} + {6'b000000, count_ones(merge_s)};
    coal_nxt_s = coal_sum_s[8] ? 8'hFF : coal_sum_s[7:0];
    case (sel_s)
      3'd1:    arg_sel_s = final_arg_r;
      3'd2:    arg_sel_s = win_arg_r;
      default: arg_sel_s = 2'd0;
    endcase
  end

  // Edge history, pending requests, per-event arguments and coalesce counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_d_r      <= 7'd0;
      pending_r   <= 7'd0;
      coal_r      <= 8'd0;
      final_arg_r <= 2'd0;
      win_arg_r   <= 2'd0;
    end else begin
      ev_d_r    <= ev_in_s;
      pending_r <= pend_nxt_s;
      coal_r    <= coal_nxt_s;
      if (edge_s[1]) final_arg_r <= game_result;
      if (edge_s[2]) win_arg_r   <= game_win;
    end
  end

  // Transfer sequencing: issue, wait for completion or timeout, then hold the display
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      tx_req_r   <= 1'b0;
      code_r     <= 3'd0;
      arg_r      <= 2'd0;
      busy_r     <= 1'b0;
      tout_r     <= 1'b0;
      timer_r    <= 32'd0;
      hold_cnt_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_s) begin
            code_r   <= sel_s + 3'd1;
            arg_r    <= arg_sel_s;
            tx_req_r <= 1'b1;
            busy_r   <= 1'b1;
            state_r  <= ISSUE;
          end
        end
        ISSUE: begin
          if (tx_ack) begin
            tx_req_r <= 1'b0;
            timer_r  <= 32'd0;
            state_r  <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_done || (timer_r == TIMEOUT_LAST)) begin
            if (!tx_done) tout_r <= 1'b1;
            hold_cnt_r <= 32'd0;
            if (HOLD_EN) begin
              state_r <= HOLD;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            timer_r <= timer_r + 32'd1;
          end
        end
        HOLD: begin
          // A restart cuts the hold short so the restart message shows at once
          if (edge_s[0] || (hold_cnt_r == HOLD_LAST)) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            hold_cnt_r <= hold_cnt_r + 32'd1;
          end
        end
        default: begin
          state_r  <= IDLE;
          tx_req_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_req       = tx_req_r;
  assign msg_code     = code_r;
  assign msg_arg      = arg_r;
  assign pending      = pending_r;
  assign busy         = busy_r;
  assign coalesce_cnt = coal_r;
  assign timeout_err  = tout_r;

endmodule

// File: tb/tb_i2c_event_scheduler.sv
// Bench for i2c_event_scheduler: directed handshake/timing scenarios followed by randomized
// event bursts checked against a set-based model of pending requests.
module tb_i2c_event_scheduler;
  localparam int HOLD = 4;
  localparam int TOUT = 16;

  logic clk = 1'b0;
  logic rst, restart, game_final, i2c_show_signal;
  logic up_signal_p1, down_signal_p1, up_signal_p2, down_signal_p2;
  logic [1:0] game_result, game_win, msg_arg;
  logic tx_req, tx_ack, tx_done, busy, timeout_err;
  logic [2:0] msg_code;
  logic [6:0] pending;
  logic [7:0] coalesce_cnt;

  int tests = 0;
  int fails = 0;

  bit         mp [7];
  logic [1:0] m_final_arg, m_win_arg;
  int         m_coal;
  bit         m_tout;

  logic [6:0] mask;
  logic [1:0] rw, rr, ea;
  logic [2:0] ec;
  int         reqs, ph, nb;
  logic       prev_req;

  i2c_event_scheduler #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst(rst), .restart(restart), .game_final(game_final),
    .game_result(game_result), .i2c_show_signal(i2c_show_signal), .game_win(game_win),
    .up_signal_p1(up_signal_p1), .down_signal_p1(down_signal_p1),
    .up_signal_p2(up_signal_p2), .down_signal_p2(down_signal_p2),
    .tx_req(tx_req), .msg_code(msg_code), .msg_arg(msg_arg), .tx_ack(tx_ack),
    .tx_done(tx_done), .pending(pending), .busy(busy), .coalesce_cnt(coalesce_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle pulse on the events in mask (bit order = pending bit order)
  task automatic pulse(input logic [6:0] m, input logic [1:0] w, input logic [1:0] r);
    restart = m[0]; game_final = m[1]; i2c_show_signal = m[2]; up_signal_p1 = m[3];
    down_signal_p1 = m[4]; up_signal_p2 = m[5]; down_signal_p2 = m[6];
    game_win = w; game_result = r;
    tick();
    restart = 1'b0; game_final = 1'b0; i2c_show_signal = 1'b0; up_signal_p1 = 1'b0;
    down_signal_p1 = 1'b0; up_signal_p2 = 1'b0; down_signal_p2 = 1'b0;
  endtask

  task automatic do_ack();
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
  endtask

  task automatic do_done();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
  endtask

  task automatic wait_req();
    for (int n = 0; n < 100 && tx_req !== 1'b1; n++) tick();
    check("req_seen", 32'(tx_req), 32'd1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && busy !== 1'b0; n++) tick();
    check("idle_seen", 32'(busy), 32'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 7; i++) mp[i] = 1'b0;
    m_final_arg = 2'd0; m_win_arg = 2'd0; m_coal = 0; m_tout = 1'b0;
  endtask

  task automatic model_bump();
    m_coal = (m_coal < 255) ? m_coal + 1 : 255;
  endtask

  task automatic model_apply(input logic [6:0] m, input logic [1:0] w, input logic [1:0] r);
    for (int i = 1; i < 7; i++) begin
      if (m[i]) begin
        if (mp[i]) model_bump();
        mp[i] = 1'b1;
      end
    end
    if (m[1]) m_final_arg = r;
    if (m[2]) m_win_arg = w;
    if (m[0]) begin
      if (mp[0]) model_bump();
      for (int i = 1; i < 7; i++) mp[i] = 1'b0;
      mp[0] = 1'b1;
    end
  endtask

  function automatic logic [6:0] model_vec();
    logic [6:0] v;
    for (int i = 0; i < 7; i++) v[i] = mp[i];
    return v;
  endfunction

  // Remove and return the highest-priority (lowest-index) pending message
  task automatic model_pop(output logic [2:0] code, output logic [1:0] arg);
    int k;
    k = -1;
    for (int i = 6; i >= 0; i--) if (mp[i]) k = i;
    code = 3'd0; arg = 2'd0;
    if (k >= 0) begin
      mp[k] = 1'b0;
      code = 3'(k + 1);
      arg = (k == 1) ? m_final_arg : (k == 2) ? m_win_arg : 2'd0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; restart = 1'b0; game_final = 1'b0; i2c_show_signal = 1'b0;
    up_signal_p1 = 1'b0; down_signal_p1 = 1'b0; up_signal_p2 = 1'b0; down_signal_p2 = 1'b0;
    game_result = 2'd0; game_win = 2'd0; tx_ack = 1'b0; tx_done = 1'b0;
    tick(); tick();
    check("rst_tx_req", 32'(tx_req), 32'd0);
    check("rst_code", 32'(msg_code), 32'd0);
    check("rst_arg", 32'(msg_arg), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_coal", 32'(coalesce_cnt), 32'd0);
    check("rst_tout", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    tick();

    // Single P1-up event with exact handshake timing
    pulse(7'b0001000, 2'd0, 2'd0);
    check("single_pending", 32'(pending), 32'b0001000);
    tick();
    check("single_req", 32'(tx_req), 32'd1);
    check("single_code", 32'(msg_code), 32'd4);
    check("single_arg", 32'(msg_arg), 32'd0);
    check("single_pend_clr", 32'(pending), 32'd0);
    tick();
    do_ack();
    check("single_req_drop", 32'(tx_req), 32'd0);
    repeat (4) tick();
    do_done();
    repeat (3) tick();
    check("single_busy_hold", 32'(busy), 32'd1);
    tick();
    check("single_busy_end", 32'(busy), 32'd0);
    check("single_code_kept", 32'(msg_code), 32'd4);

    // Priority: round win beats P2 up; gap done->next req is HOLD+2
    pulse(7'b0100100, 2'd2, 2'd0);
    check("prio_pending", 32'(pending), 32'b0100100);
    tick();
    check("prio_code1", 32'(msg_code), 32'd3);
    check("prio_arg1", 32'(msg_arg), 32'd2);
    check("prio_pending1", 32'(pending), 32'b0100000);
    do_ack();
    do_done();
    repeat (4) tick();
    check("prio_gap_early", 32'(tx_req), 32'd0);
    tick();
    check("prio_gap_req", 32'(tx_req), 32'd1);
    check("prio_code2", 32'(msg_code), 32'd6);
    check("prio_pending2", 32'(pending), 32'd0);
    do_ack(); do_done(); wait_idle();

    // Coalesce: three P1-down edges while busy with a P2-down message
    pulse(7'b1000000, 2'd0, 2'd0);
    tick();
    check("coal_first_code", 32'(msg_code), 32'd7);
    repeat (3) begin
      pulse(7'b0010000, 2'd0, 2'd0);
      tick();
    end
    check("coal_pending", 32'(pending), 32'b0010000);
    check("coal_cnt", 32'(coalesce_cnt), 32'd2);
    do_ack(); do_done();
    wait_req();
    check("coal_code", 32'(msg_code), 32'd5);
    do_ack(); do_done(); wait_idle();

    // Restart during HOLD flushes pending and aborts the hold
    pulse(7'b0100000, 2'd0, 2'd0);
    tick();
    pulse(7'b1001100, 2'd1, 2'd0);
    check("flush_pending_pre", 32'(pending), 32'b1001100);
    do_ack(); do_done();
    tick();
    pulse(7'b0000001, 2'd0, 2'd0);
    check("flush_pending", 32'(pending), 32'd1);
    check("flush_hold_abort", 32'(busy), 32'd0);
    tick();
    check("flush_req", 32'(tx_req), 32'd1);
    check("flush_code", 32'(msg_code), 32'd1);
    check("flush_pending_clr", 32'(pending), 32'd0);
    do_ack(); do_done();
    reqs = 0;
    repeat (30) begin
      if (tx_req === 1'b1) reqs++;
      tick();
    end
    check("flush_no_more_req", 32'(reqs), 32'd0);
    check("flush_idle", 32'(busy), 32'd0);

    // Timeout in WAIT_DONE, then continue with the next pending message
    pulse(7'b0001000, 2'd0, 2'd0);
    tick();
    pulse(7'b0010000, 2'd0, 2'd0);
    do_ack();
    repeat (15) tick();
    check("tout_not_yet", 32'(timeout_err), 32'd0);
    tick();
    check("tout_set", 32'(timeout_err), 32'd1);
    wait_req();
    check("tout_next_code", 32'(msg_code), 32'd5);
    do_ack(); do_done(); wait_idle();
    check("tout_sticky", 32'(timeout_err), 32'd1);

    // game_final held high: a level produces exactly one message
    game_result = 2'd1; game_final = 1'b1;
    reqs = 0; ph = 0;
    for (int c = 0; c < 100; c++) begin
      tx_ack = 1'b0; tx_done = 1'b0;
      if (ph == 1) begin
        tx_done = 1'b1; ph = 0;
      end else if (tx_req === 1'b1) begin
        reqs++;
        check("level_code", 32'(msg_code), 32'd2);
        check("level_arg", 32'(msg_arg), 32'd1);
        tx_ack = 1'b1; ph = 1;
      end
      tick();
    end
    tx_ack = 1'b0; tx_done = 1'b0; game_final = 1'b0;
    tick();
    check("level_count", 32'(reqs), 32'd1);
    wait_idle();

    // Reset in the middle of a transfer
    pulse(7'b0000100, 2'd3, 2'd0);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_req", 32'(tx_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_code", 32'(msg_code), 32'd0);
    check("mid_rst_coal", 32'(coalesce_cnt), 32'd0);
    check("mid_rst_tout", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    tick();
    model_reset();

    // Randomized bursts: events injected while a message awaits ack
    for (int m = 0; m < 40; m++) begin
      if (model_vec() == 7'd0) begin
        wait_idle();
        mask = {6'($urandom_range(1, 63)), 1'b0};
        rw = 2'($urandom_range(0, 3)); rr = 2'($urandom_range(0, 3));
        pulse(mask, rw, rr);
        model_apply(mask, rw, rr);
      end
      wait_req();
      model_pop(ec, ea);
      check("rnd_code", 32'(msg_code), 32'(ec));
      check("rnd_arg", 32'(msg_arg), 32'(ea));
      check("rnd_pending", 32'(pending), 32'(model_vec()));
      nb = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 5) == 0) mask = 7'b0000001;
        else mask = {6'($urandom_range(1, 63)), 1'b0};
        rw = 2'($urandom_range(0, 3)); rr = 2'($urandom_range(0, 3));
        pulse(mask, rw, rr);
        model_apply(mask, rw, rr);
        check("rnd_burst_pending", 32'(pending), 32'(model_vec()));
        tick();
      end
      do_ack();
      if ($urandom_range(0, 7) == 0) begin
        repeat (TOUT) tick();
        m_tout = 1'b1;
      end else begin
        repeat ($urandom_range(0, 6)) tick();
        do_done();
      end
      check("rnd_tout", 32'(timeout_err), 32'(m_tout));
      check("rnd_coal", 32'(coalesce_cnt), 32'(m_coal));
    end
    for (int d = 0; d < 7 && model_vec() != 7'd0; d++) begin
      wait_req();
      model_pop(ec, ea);
      check("drain_code", 32'(msg_code), 32'(ec));
      do_ack(); do_done();
    end
    wait_idle();

    // Coalesce counter saturation
    pulse(7'b1000000, 2'd0, 2'd0);
    model_apply(7'b1000000, 2'd0, 2'd0);
    wait_req();
    model_pop(ec, ea);
    check("sat_first_code", 32'(msg_code), 32'(ec));
    for (int s = 0; s < 260; s++) begin
      pulse(7'b0100000, 2'd0, 2'd0);
      model_apply(7'b0100000, 2'd0, 2'd0);
      tick();
    end
    check("sat_coal_model", 32'(coalesce_cnt), 32'(m_coal));
    check("sat_coal_max", 32'(coalesce_cnt), 32'd255);
    do_ack(); do_done();
    wait_req();
    check("sat_next_code", 32'(msg_code), 32'd6);
    do_ack(); do_done(); wait_idle();
    check("final_pending", 32'(pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
